// File: rtl/crane_wb_pkg.sv
// Shared writeback definitions: source encodings, register-address width and
// arbiter pointer states used across the writeback path.
package crane_wb_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int XLEN_DEFAULT = 32;

    // Wide enough for the largest legal starvation limit (15).
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MDU = 2'd2
    } wb_src_e;

    typedef enum logic {
        PTR_LSU = 1'b0,
        PTR_MDU = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin arbiter for the secondary writeback sources.
// req[0]/gnt[0] is LSU and req[1]/gnt[1] is MDU; en low blocks every grant.
module wb_rr_arb2
    import crane_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_ptr_e ptr_q;
    rr_ptr_e ptr_d;

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (ptr_q == PTR_LSU) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
        // The winner moves to the back of the line.
        if (gnt[0]) begin
            ptr_d = PTR_MDU;
        end else if (gnt[1]) begin
            ptr_d = PTR_LSU;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_LSU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arb.sv
// Writeback arbiter for the integer register file write port: ALU first, LSU/MDU
// round-robin, starvation stall. Statistics counters exist only under
// REGFILE_WB_ARB_STATS_EN.
module regfile_wb_arb
    import crane_wb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int XLEN       = XLEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    output logic                  stall_o,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [XLEN-1:0]       wr_data,
    output logic [1:0]            wr_src,
    output logic [31:0]           stat_alu_cnt,
    output logic [31:0]           stat_lsu_cnt,
    output logic [31:0]           stat_mdu_cnt,
    output logic [31:0]           stat_stall_cnt
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    logic [1:0]              sec_gnt;
    logic                    sec_valid;
    logic                    sec_taken;
    logic                    accept;
    logic [REG_ADDR_W-1:0]   sel_rd;
    logic [XLEN-1:0]         sel_data;
    wb_src_e                 sel_src;
    logic [STARVE_CNT_W-1:0] starve_q;
    logic [STARVE_CNT_W-1:0] starve_d;
    logic                    stall_q;
    logic                    we_q;
    logic [REG_ADDR_W-1:0]   wr_addr_q;
    logic [XLEN-1:0]         wr_data_q;
    wb_src_e                 wr_src_q;

    // Gating with rst_n keeps the readies low while reset is held.
    wb_rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rst_n & ~alu_valid),
        .req   ({mdu_valid, lsu_valid}),
        .gnt   (sec_gnt)
    );

    assign lsu_ready = sec_gnt[0];
    assign mdu_ready = sec_gnt[1];
    assign sec_valid = lsu_valid | mdu_valid;
    assign sec_taken = |sec_gnt;
    assign accept    = alu_valid | sec_taken;

    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        sel_src  = SRC_ALU;
        if (!alu_valid) begin
            if (sec_gnt[0]) begin
                sel_rd   = lsu_rd;
                sel_data = lsu_data;
                sel_src  = SRC_LSU;
            end else if (sec_gnt[1]) begin
                sel_rd   = mdu_rd;
                sel_data = mdu_data;
                sel_src  = SRC_MDU;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (sec_taken || !sec_valid) begin
            starve_d = '0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            if (sec_taken) begin
                stall_q <= 1'b0;
            end else if (starve_d == STARVE_LIM) begin
                stall_q <= 1'b1;
            end
        end
    end

    // Address/data/source hold between grants; only we pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= SRC_ALU;
        end else begin
            we_q <= accept && (sel_rd != '0);
            if (accept) begin
                wr_addr_q <= sel_rd;
                wr_data_q <= sel_data;
                wr_src_q  <= sel_src;
            end
        end
    end

    assign stall_o = stall_q;
    assign we      = we_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_src  = wr_src_q;

    // The pipeline must keep the ALU quiet while stalled; the ALU still wins.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(alu_valid && stall_q))
            else $error("regfile_wb_arb: alu_valid asserted while stall_o is high");
        end
    end

`ifdef REGFILE_WB_ARB_STATS_EN
    logic [31:0] alu_cnt_q;
    logic [31:0] lsu_cnt_q;
    logic [31:0] mdu_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_cnt_q   <= '0;
            lsu_cnt_q   <= '0;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (alu_valid) alu_cnt_q   <= alu_cnt_q + 32'd1;
            if (lsu_ready) lsu_cnt_q   <= lsu_cnt_q + 32'd1;
            if (mdu_ready) mdu_cnt_q   <= mdu_cnt_q + 32'd1;
            if (stall_q)   stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stat_alu_cnt   = alu_cnt_q;
    assign stat_lsu_cnt   = lsu_cnt_q;
    assign stat_mdu_cnt   = mdu_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`else
    assign stat_alu_cnt   = '0;
    assign stat_lsu_cnt   = '0;
    assign stat_mdu_cnt   = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb with STARVE_MAX=4; stat expectations follow
// REGFILE_WB_ARB_STATS_EN so both builds are covered.
module tb_regfile_wb_arb;

`ifdef REGFILE_WB_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        stall_o;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_src;
    logic [31:0] stat_alu_cnt;
    logic [31:0] stat_lsu_cnt;
    logic [31:0] stat_mdu_cnt;
    logic [31:0] stat_stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    regfile_wb_arb #(.STARVE_MAX(4), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_rd         (lsu_rd),
        .lsu_data       (lsu_data),
        .mdu_valid      (mdu_valid),
        .mdu_ready      (mdu_ready),
        .mdu_rd         (mdu_rd),
        .mdu_data       (mdu_data),
        .stall_o        (stall_o),
        .we             (we),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_src         (wr_src),
        .stat_alu_cnt   (stat_alu_cnt),
        .stat_lsu_cnt   (stat_lsu_cnt),
        .stat_mdu_cnt   (stat_mdu_cnt),
        .stat_stall_cnt (stat_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_write(input string tag, input logic [4:0] addr,
                               input logic [31:0] data, input logic [1:0] src);
        check({tag, "_we"},   {31'd0, we},      32'd1);
        check({tag, "_addr"}, {27'd0, wr_addr}, {27'd0, addr});
        check({tag, "_data"}, wr_data,          data);
        check({tag, "_src"},  {30'd0, wr_src},  {30'd0, src});
    endtask

    task automatic check_stats(input string tag, input int a, input int l, input int m, input int s);
        check({tag, "_stat_alu"},   stat_alu_cnt,   STATS ? 32'(a) : 32'd0);
        check({tag, "_stat_lsu"},   stat_lsu_cnt,   STATS ? 32'(l) : 32'd0);
        check({tag, "_stat_mdu"},   stat_mdu_cnt,   STATS ? 32'(m) : 32'd0);
        check({tag, "_stat_stall"}, stat_stall_cnt, STATS ? 32'(s) : 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},        {31'd0, we},        32'd0);
        check({tag, "_addr"},      {27'd0, wr_addr},   32'd0);
        check({tag, "_data"},      wr_data,            32'd0);
        check({tag, "_src"},       {30'd0, wr_src},    32'd0);
        check({tag, "_stall"},     {31'd0, stall_o},   32'd0);
        check({tag, "_lsu_ready"}, {31'd0, lsu_ready}, 32'd0);
        check({tag, "_mdu_ready"}, {31'd0, mdu_ready}, 32'd0);
        check_stats(tag, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;

        // Reset state, with requests present to prove the readies are gated.
        repeat (2) @(negedge clk);
        lsu_valid = 1'b1;
        mdu_valid = 1'b1;
        #1;
        check_all_zero("reset");
        lsu_valid = 1'b0;
        mdu_valid = 1'b0;

        // Round-robin: LSU first after reset, then MDU.
        @(negedge clk);
        rst_n     = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hAAAA_0000;
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'hBBBB_0000;
        #1;
        check("rr_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        check("rr_mdu_wait",  {31'd0, mdu_ready}, 32'd0);
        @(negedge clk);
        check_write("rr_w1", 5'd3, 32'hAAAA_0000, 2'd1);
        lsu_valid = 1'b0;
        #1;
        check("rr_mdu_ready", {31'd0, mdu_ready}, 32'd1);
        @(negedge clk);
        check_write("rr_w2", 5'd4, 32'hBBBB_0000, 2'd2);
        check_stats("rr", 0, 1, 1, 0);
        mdu_valid = 1'b0;
        @(negedge clk);
        check("rr_idle_we", {31'd0, we}, 32'd0);

        // Backpressure: LSU held behind two ALU cycles, then written unchanged.
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0011;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'hCAFE_0009;
        #1;
        check("bp_hold1", {31'd0, lsu_ready}, 32'd0);
        @(negedge clk);
        check_write("bp_alu1", 5'd7, 32'h0000_0011, 2'd0);
        alu_rd = 5'd8; alu_data = 32'h0000_0022;
        #1;
        check("bp_hold2", {31'd0, lsu_ready}, 32'd0);
        @(negedge clk);
        check_write("bp_alu2", 5'd8, 32'h0000_0022, 2'd0);
        alu_valid = 1'b0;
        #1;
        check("bp_ready", {31'd0, lsu_ready}, 32'd1);
        @(negedge clk);
        check_write("bp_lsu", 5'd9, 32'hCAFE_0009, 2'd1);
        check("bp_no_stall", {31'd0, stall_o}, 32'd0);
        lsu_valid = 1'b0;

        // rd=0: handshake completes, source recorded, no write.
        mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hDEAD_BEEF;
        #1;
        check("rd0_ready", {31'd0, mdu_ready}, 32'd1);
        @(negedge clk);
        check("rd0_we",  {31'd0, we},     32'd0);
        check("rd0_src", {30'd0, wr_src}, 32'd2);
        check_stats("rd0", 2, 2, 2, 0);
        mdu_valid = 1'b0;

        // Starvation: ALU every cycle blocks the LSU until stall_o rises.
        alu_valid = 1'b1; alu_rd = 5'd1;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'h5555_000A;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            alu_data = 32'(i);
            #1;
            check($sformatf("starve_no_stall_%0d", i), {31'd0, stall_o},   32'd0);
            check($sformatf("starve_blocked_%0d", i),  {31'd0, lsu_ready}, 32'd0);
        end
        @(negedge clk);
        check("starve_stall", {31'd0, stall_o}, 32'd1);
        alu_valid = 1'b0;
        #1;
        check("starve_ready", {31'd0, lsu_ready}, 32'd1);
        @(negedge clk);
        check("starve_clear", {31'd0, stall_o}, 32'd0);
        check_write("starve_w", 5'd10, 32'h5555_000A, 2'd1);
        check_stats("starve", 6, 3, 2, 1);
        lsu_valid = 1'b0;

        // All three valid: ALU wins and the pointer (now MDU) is untouched.
        alu_valid = 1'b1; alu_rd = 5'd2;  alu_data = 32'h0000_0033;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'h0000_000B;
        mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'h0000_000C;
        #1;
        check("tri_lsu_blocked", {31'd0, lsu_ready}, 32'd0);
        check("tri_mdu_blocked", {31'd0, mdu_ready}, 32'd0);
        @(negedge clk);
        check_write("tri_alu", 5'd2, 32'h0000_0033, 2'd0);
        alu_valid = 1'b0;
        #1;
        check("tri_mdu_first", {31'd0, mdu_ready}, 32'd1);
        check("tri_lsu_waits", {31'd0, lsu_ready}, 32'd0);
        @(negedge clk);
        check_write("tri_mdu", 5'd12, 32'h0000_000C, 2'd2);
        mdu_valid = 1'b0;
        #1;
        check("tri_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        @(negedge clk);
        check_write("tri_lsu", 5'd11, 32'h0000_000B, 2'd1);
        lsu_valid = 1'b0;

        // Reset in the middle of traffic clears everything immediately.
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h0000_0099;
        lsu_valid = 1'b1; lsu_rd = 5'd13;
        @(negedge clk);
        check("mid_we", {31'd0, we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n     = 1'b1;
        lsu_valid = 1'b0;
        alu_rd    = 5'd5; alu_data = 32'h1234_5678;
        @(negedge clk);
        check_write("post_reset", 5'd5, 32'h1234_5678, 2'd0);
        check_stats("post_reset", 1, 0, 0, 0);
        alu_valid = 1'b0;
        @(negedge clk);
        check("post_reset_we_drop", {31'd0, we}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
